lab7_io_slave: RTL and testbench
================================

LAB7_IO_SLAVE -- requirements
Module: lab7_io_slave

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 50000, stable cycles required to accept a button level change (1 ms at 50 MHz); legal range 1..65535.
REQ-002 clk_clk  input  1  system clock; all logic on the rising edge.
REQ-003 reset_reset_n  input  1  synchronous, active-low reset.
REQ-004 avs_address  input  3  word address of the Avalon-MM slave port.
REQ-005 avs_read  input  1  read strobe.
REQ-006 avs_write  input  1  write strobe.
REQ-007 avs_writedata  input  32  write data.
REQ-008 avs_readdata  output  32  registered read data.
REQ-009 avs_readdatavalid  output  1  qualifies avs_readdata.
REQ-010 avs_irq  output  1  level interrupt request.
REQ-011 led_wire_export  output  8  LED register drive.
REQ-012 switch_export  input  8  asynchronous slide switches.
REQ-013 buttons_export  input  4  asynchronous push buttons, active-low (0 = pressed).

Function
REQ-014 Register map (word address): 0 LED (RW, bits 7:0); 1 SWITCH (RO, 7:0); 2 BUTTON (RO, 3:0, debounced, 1 = pressed); 3 EDGE (RW1C, 3:0); 4 IRQMASK (RW, 3:0); 5-7 read as 0, writes ignored.
REQ-015 Unused upper readdata bits of every register shall read 0.
REQ-016 No waitrequest: every access completes in one cycle; a write takes effect on the strobe edge.
REQ-017 Read latency shall be exactly 1: avs_readdatavalid high for one cycle, the cycle after avs_read, with data sampled in the cycle avs_read was high.
REQ-018 Back-to-back reads on consecutive cycles shall each produce one readdatavalid pulse, in order.
REQ-019 avs_read and avs_write asserted together: the write is performed; the read returns the pre-write value.
REQ-020 switch_export and buttons_export shall each pass through a 2-flop synchronizer before any use.
REQ-021 Per button: a counter resets to 0 whenever the synchronized raw level equals the debounced level; otherwise it increments; when it reaches DEBOUNCE_CYCLES-1 the debounced level takes the raw level and the counter clears.
REQ-022 A glitch shorter than DEBOUNCE_CYCLES cycles shall not change the debounced level.
REQ-023 A debounced released-to-pressed transition shall set the matching EDGE bit in the same cycle the debounced level changes; releases shall not set EDGE.
REQ-024 Writing 1 to an EDGE bit clears it; writing 0 leaves it unchanged.
REQ-025 A new edge and a clear of the same EDGE bit in the same cycle: the bit shall remain set (set wins).
REQ-026 avs_irq = OR over i of (EDGE[i] AND IRQMASK[i]), registered, asserted the cycle after the enabling condition.
REQ-027 LED and IRQMASK shall hold their values until written or reset.

Reset
REQ-028 While reset_reset_n is low at a clock edge: led_wire_export = 0x00, IRQMASK = 0, EDGE = 0, avs_readdata = 0, avs_readdatavalid = 0, avs_irq = 0.
REQ-029 Reset shall load the synchronizers and debounced levels with "not pressed" and clear all debounce counters.
REQ-030 Reset asserted the cycle after a read shall suppress that read's readdatavalid pulse.
REQ-031 No edge shall be captured in the first DEBOUNCE_CYCLES cycles after reset, even if a button is held through reset.

Verification (DEBOUNCE_CYCLES = 4 unless stated)
REQ-032 Write 0xA5 to address 0, then read address 0 -> led_wire_export = 0xA5 the next cycle; readdatavalid one cycle after the read, readdata = 0x000000A5.
REQ-033 switch_export = 0x3C, wait 3 cycles, read address 1 -> readdata = 0x0000003C.
REQ-034 buttons_export[2] driven low for 2 cycles, then high -> BUTTON and EDGE remain 0. Held low for 10 cycles -> BUTTON = 0x4, EDGE = 0x4.
REQ-035 IRQMASK = 0x4, button 2 pressed -> avs_irq = 1; write 0x4 to address 3 -> EDGE = 0 and avs_irq = 0 one cycle later.
REQ-036 EDGE[0] set-edge coincides with a write of 0x1 to address 3 -> EDGE[0] = 1 afterwards.
REQ-037 Assert reset mid-debounce and with LED = 0xFF -> all outputs reach their REQ-028 values; a held button produces no edge until 4 cycles after reset release.

Source files
------------

// File: rtl/lab7_io_slave.sv
// Avalon-MM I/O slave for the lab board: LED register, synchronized switches,
// debounced push buttons with press-edge capture and a maskable level interrupt.
module lab7_io_slave #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [2:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        avs_readdatavalid,
    output logic        avs_irq,
    output logic [7:0]  led_wire_export,
    input  logic [7:0]  switch_export,
    input  logic [3:0]  buttons_export
);

    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [7:0]  sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
    logic [3:0]  btn_meta_q, btn_meta_d, btn_sync_q, btn_sync_d;
    logic [3:0]  btn_db_q, btn_db_d, press;
    logic [15:0] cnt_q [4];
    logic [15:0] cnt_d [4];
    logic [7:0]  led_q, led_d;
    logic [3:0]  mask_q, mask_d, edg_q, edg_d, clr;
    logic [31:0] rdata_q, rdata_d, reg_mux;
    logic        rvalid_q, rvalid_d, irq_q, irq_d;
    logic        unused_wdata;

    assign unused_wdata = ^avs_writedata[31:8];

    // Raw button levels are active-low; btn_db_q holds the debounced raw level.
    always_comb begin
        sw_meta_d  = switch_export;
        sw_sync_d  = sw_meta_q;
        btn_meta_d = buttons_export;
        btn_sync_d = btn_meta_q;
        btn_db_d   = btn_db_q;
        press      = '0;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (btn_sync_q[i] != btn_db_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    btn_db_d[i] = btn_sync_q[i];
                    press[i]    = ~btn_sync_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        led_d  = led_q;
        mask_d = mask_q;
        clr    = '0;
        if (avs_write) begin
            case (avs_address)
                3'd0:    led_d  = avs_writedata[7:0];
                3'd3:    clr    = avs_writedata[3:0];
                3'd4:    mask_d = avs_writedata[3:0];
                default: ;
            endcase
        end
        // A press arriving with a clear of the same bit keeps the bit set.
        edg_d = (edg_q & ~clr) | press;
        irq_d = |(edg_q & mask_q);

        reg_mux = '0;
        case (avs_address)
            3'd0:    reg_mux = {24'd0, led_q};
            3'd1:    reg_mux = {24'd0, sw_sync_q};
            3'd2:    reg_mux = {28'd0, ~btn_db_q};
            3'd3:    reg_mux = {28'd0, edg_q};
            3'd4:    reg_mux = {28'd0, mask_q};
            default: reg_mux = '0;
        endcase
        rdata_d  = avs_read ? reg_mux : rdata_q;
        rvalid_d = avs_read;
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            btn_meta_q <= '1;
            btn_sync_q <= '1;
            btn_db_q   <= '1;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
            led_q      <= '0;
            mask_q     <= '0;
            edg_q      <= '0;
            irq_q      <= 1'b0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            sw_meta_q  <= sw_meta_d;
            sw_sync_q  <= sw_sync_d;
            btn_meta_q <= btn_meta_d;
            btn_sync_q <= btn_sync_d;
            btn_db_q   <= btn_db_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
            led_q      <= led_d;
            mask_q     <= mask_d;
            edg_q      <= edg_d;
            irq_q      <= irq_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
        end
    end

    // A reset arriving while a read response is on the bus cancels that response.
    assign avs_readdatavalid = rvalid_q & reset_reset_n;
    assign avs_readdata      = rdata_q;
    assign avs_irq           = irq_q;
    assign led_wire_export   = led_q;

endmodule

// File: tb/tb_lab7_io_slave.sv
// Randomized bench for lab7_io_slave: a cycle-level register/button model feeds
// a read-response queue that an independent monitor drains and compares.
module tb_lab7_io_slave;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid, avs_irq;
    logic [7:0]  led_wire_export;
    logic [7:0]  switch_export;
    logic [3:0]  buttons_export;

    int checks = 0;
    int failures = 0;
    bit started = 1'b0;

    logic [31:0] expq[$];
    logic [7:0]  m_led, m_sw_meta, m_sw_sync;
    logic [3:0]  m_mask, m_edg, m_bm, m_bs, m_db;
    logic        m_irq, m_rst;
    int          m_run[4];

    lab7_io_slave #(.DEBOUNCE_CYCLES(D)) dut (
        .clk_clk(clk),
        .reset_reset_n(reset_n),
        .avs_address(avs_address),
        .avs_read(avs_read),
        .avs_write(avs_write),
        .avs_writedata(avs_writedata),
        .avs_readdata(avs_readdata),
        .avs_readdatavalid(avs_readdatavalid),
        .avs_irq(avs_irq),
        .led_wire_export(led_wire_export),
        .switch_export(switch_export),
        .buttons_export(buttons_export)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference model: registers as plain variables; a button level is accepted
    // once the synchronized input has disagreed with it for D consecutive cycles.
    task automatic model_step();
        logic [31:0] rd;
        logic [3:0]  set, clr;
        if (!reset_n) begin
            m_led = 0; m_mask = 0; m_edg = 0; m_irq = 0;
            m_sw_meta = 0; m_sw_sync = 0;
            m_bm = 4'hF; m_bs = 4'hF; m_db = 4'hF;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            m_rst = 1'b1;
            return;
        end
        case (avs_address)
            3'd0:    rd = {24'd0, m_led};
            3'd1:    rd = {24'd0, m_sw_sync};
            3'd2:    rd = {28'd0, ~m_db};
            3'd3:    rd = {28'd0, m_edg};
            3'd4:    rd = {28'd0, m_mask};
            default: rd = 32'd0;
        endcase
        if (avs_read) expq.push_back(rd);
        set = 4'd0;
        for (int i = 0; i < 4; i++) begin
            if (m_bs[i] != m_db[i]) m_run[i]++;
            else m_run[i] = 0;
            if (m_run[i] == D) begin
                m_db[i] = m_bs[i];
                m_run[i] = 0;
                if (!m_db[i]) set[i] = 1'b1;
            end
        end
        clr = (avs_write && avs_address == 3'd3) ? avs_writedata[3:0] : 4'd0;
        m_irq = |(m_edg & m_mask);
        m_edg = (m_edg & ~clr) | set;
        if (avs_write && avs_address == 3'd0) m_led = avs_writedata[7:0];
        if (avs_write && avs_address == 3'd4) m_mask = avs_writedata[3:0];
        m_sw_sync = m_sw_meta; m_sw_meta = switch_export;
        m_bs = m_bm; m_bm = buttons_export;
        m_rst = 1'b0;
    endtask

    task automatic cyc(input logic rn, input logic rd, input logic wr,
                       input logic [2:0] a, input logic [31:0] wd);
        reset_n = rn; avs_read = rd; avs_write = wr;
        avs_address = a; avs_writedata = wd;
        if (!rn) expq.delete();
        @(posedge clk);
        model_step();
        started = 1'b1;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 3'd0, 32'd0);
    endtask
    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        cyc(1, 0, 1, a, d);
    endtask
    task automatic rd_reg(input logic [2:0] a);
        cyc(1, 1, 0, a, 32'd0);
    endtask

    // Monitor: every read response must match the oldest queued expectation.
    logic        mon_valid_exp;
    logic [31:0] mon_data_exp;
    always @(negedge clk) begin
        if (started) begin
            mon_valid_exp = (expq.size() != 0);
            check("rvalid", {31'd0, avs_readdatavalid}, {31'd0, mon_valid_exp});
            if (mon_valid_exp) begin
                mon_data_exp = expq.pop_front();
                if (avs_readdatavalid === 1'b1) check("readdata", avs_readdata, mon_data_exp);
            end
            check("led", {24'd0, led_wire_export}, {24'd0, m_led});
            check("irq", {31'd0, avs_irq}, {31'd0, m_irq});
            if (m_rst) check("rst_readdata", avs_readdata, 32'd0);
        end
    end

    initial begin
        bit found;
        reset_n = 0; avs_read = 0; avs_write = 0; avs_address = 0; avs_writedata = 0;
        switch_export = 8'h00; buttons_export = 4'hF;
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 3'd0, 32'd0);
        idle(2);

        wr_reg(3'd0, 32'h0000_00A5);
        check("led_a5", {24'd0, led_wire_export}, 32'h0000_00A5);
        rd_reg(3'd0);
        switch_export = 8'h3C;
        idle(3);
        rd_reg(3'd1);

        buttons_export[2] = 1'b0; idle(2);
        buttons_export[2] = 1'b1; idle(6);
        rd_reg(3'd2); rd_reg(3'd3);
        buttons_export[2] = 1'b0; idle(10);
        rd_reg(3'd2); rd_reg(3'd3);
        wr_reg(3'd4, 32'h4);
        idle(1);
        check("irq_on", {31'd0, avs_irq}, 32'd1);
        wr_reg(3'd3, 32'h4);
        idle(1);
        check("irq_off", {31'd0, avs_irq}, 32'd0);
        rd_reg(3'd3);
        cyc(1, 1, 1, 3'd0, 32'h0000_0011);

        // Clear EDGE[0] on exactly the cycle its press is accepted.
        buttons_export[0] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_bs[0] == 1'b0 && m_db[0] == 1'b1 && m_run[0] == D - 1) begin
                wr_reg(3'd3, 32'h1);
                found = 1'b1;
            end else idle(1);
        end
        check("edge0_align", {31'd0, found}, 32'd1);
        rd_reg(3'd3);
        check("edge0_set_wins", {28'd0, m_edg}, {28'd0, m_edg | 4'h1});

        // Read immediately followed by reset: its response must be dropped.
        rd_reg(3'd0);
        cyc(0, 0, 0, 3'd0, 32'd0);
        buttons_export = 4'hF;
        idle(8);

        // Reset mid-debounce with LEDs lit and a button held through reset.
        wr_reg(3'd0, 32'hFF);
        buttons_export[1] = 1'b0;
        idle(3);
        cyc(0, 0, 0, 3'd0, 32'd0);
        cyc(0, 0, 0, 3'd0, 32'd0);
        check("rst_led", {24'd0, led_wire_export}, 32'd0);
        for (int i = 0; i < 10; i++) rd_reg(3'd3);
        rd_reg(3'd2);
        buttons_export = 4'hF;
        idle(8);

        for (int n = 0; n < 1500; n++) begin
            int op;
            logic [2:0] a;
            if ($urandom_range(0, 5) == 0) begin
                int b = $urandom_range(0, 3);
                buttons_export[b] = ~buttons_export[b];
            end
            if ($urandom_range(0, 7) == 0) switch_export = 8'($urandom);
            op = $urandom_range(0, 9);
            a  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 149) == 0) cyc(0, 0, 0, 3'd0, 32'd0);
            else if (op < 4) rd_reg(a);
            else if (op < 6) wr_reg(a, $urandom);
            else if (op == 6) cyc(1, 1, 1, a, $urandom);
            else idle(1);
        end

        idle(3);
        check("queue_drained", expq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
